// File: rtl/riscv_pkg.sv
// Shared pipeline definitions: hazard-unit state encoding, major opcodes and ALUOp codes.
package riscv_pkg;

   typedef enum logic [1:0] {
      HZ_RUN      = 2'd0,
      HZ_STALL    = 2'd1,
      HZ_FLUSH    = 2'd2,
      HZ_MEM_WAIT = 2'd3
   } hz_state_e;

   localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   localparam logic [1:0] ALUOP_LDST   = 2'b00;
   localparam logic [1:0] ALUOP_BRANCH = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE  = 2'b10;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable and synchronous active-low clear; sticks at all-ones.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt <= '0;
      end else if (en && (cnt != '1)) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/hazard_control_unit.sv
// Five-stage pipeline hazard control: memory-wait freeze, taken-branch flush, load-use stall.
// Optional performance counters are built only when HAZ_PERF_CNT_EN is defined.
module hazard_control_unit
   import riscv_pkg::*;
#(
   parameter int WAIT_LIMIT = 255,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic [4:0]       ex_rd,
   input  logic             ex_memread,
   input  logic             mem_branch_taken,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             ctrl_bubble,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             ex_mem_flush,
   output logic             pipe_hold,
   output logic [1:0]       hz_state,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic [CNT_W-1:0] wait_cnt
);

   localparam int WW = $clog2(WAIT_LIMIT + 1);

   hz_state_e     state_q;
   hz_state_e     state_d;
   logic [WW-1:0] wait_q;
   logic          freeze;
   logic          flush;
   logic          load_use;
   logic          stall;

   // Handshake: a data access is outstanding while mem_req is high and completes in the
   // cycle mem_ready is also high; every earlier cycle of that access freezes the pipe.
   always_comb begin
      freeze   = mem_req & ~mem_ready;
      flush    = mem_branch_taken & ~freeze;
      load_use = ex_memread && (ex_rd != 5'd0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
      stall    = load_use & ~freeze & ~flush;
   end

   always_comb begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      ctrl_bubble  = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_flush = 1'b0;
      pipe_hold    = 1'b0;
      state_d      = HZ_RUN;
      if (!reset) begin
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         ctrl_bubble = 1'b1;
      end else if (freeze) begin
         // A branch in the held MEM stage is re-presented once the access completes.
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         pipe_hold   = 1'b1;
         state_d     = HZ_MEM_WAIT;
      end else if (flush) begin
         if_id_flush  = 1'b1;
         id_ex_flush  = 1'b1;
         ex_mem_flush = 1'b1;
         state_d      = HZ_FLUSH;
      end else if (stall) begin
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         ctrl_bubble = 1'b1;
         state_d     = HZ_STALL;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= HZ_RUN;
         wait_q      <= '0;
         mem_timeout <= 1'b0;
      end else begin
         state_q <= state_d;
         if (freeze) begin
            if (wait_q != WW'(WAIT_LIMIT)) begin
               wait_q <= wait_q + 1'b1;
            end
            if (wait_q >= WW'(WAIT_LIMIT - 1)) begin
               mem_timeout <= 1'b1;
            end
         end else begin
            wait_q <= '0;
         end
      end
   end

   assign hz_state = state_q;

`ifdef HAZ_PERF_CNT_EN
   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .en    (reset & stall),
      .cnt   (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .reset (reset),
      .en    (reset & flush),
      .cnt   (flush_cnt)
   );

   sat_counter #(.W(CNT_W)) u_wait_cnt (
      .clk   (clk),
      .reset (reset),
      .en    (reset & freeze),
      .cnt   (wait_cnt)
   );
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
   assign wait_cnt  = '0;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit (WAIT_LIMIT=4, CNT_W=4); expectations follow
// whether HAZ_PERF_CNT_EN is defined for the build.
module tb_hazard_control_unit;

   localparam int WAIT_LIMIT = 4;
   localparam int CNT_W      = 4;
`ifdef HAZ_PERF_CNT_EN
   localparam int PERF = 1;
`else
   localparam int PERF = 0;
`endif

   logic             clk = 1'b0;
   logic             reset;
   logic [4:0]       id_rs1, id_rs2, ex_rd;
   logic             ex_memread, mem_branch_taken, mem_req, mem_ready;
   logic             pc_write, if_id_write, ctrl_bubble;
   logic             if_id_flush, id_ex_flush, ex_mem_flush, pipe_hold;
   logic [1:0]       hz_state;
   logic             mem_timeout;
   logic [CNT_W-1:0] stall_cnt, flush_cnt, wait_cnt;

   int checks = 0;
   int errors = 0;

   hazard_control_unit #(.WAIT_LIMIT(WAIT_LIMIT), .CNT_W(CNT_W)) dut (
      .clk              (clk),
      .reset            (reset),
      .id_rs1           (id_rs1),
      .id_rs2           (id_rs2),
      .ex_rd            (ex_rd),
      .ex_memread       (ex_memread),
      .mem_branch_taken (mem_branch_taken),
      .mem_req          (mem_req),
      .mem_ready        (mem_ready),
      .pc_write         (pc_write),
      .if_id_write      (if_id_write),
      .ctrl_bubble      (ctrl_bubble),
      .if_id_flush      (if_id_flush),
      .id_ex_flush      (id_ex_flush),
      .ex_mem_flush     (ex_mem_flush),
      .pipe_hold        (pipe_hold),
      .hz_state         (hz_state),
      .mem_timeout      (mem_timeout),
      .stall_cnt        (stall_cnt),
      .flush_cnt        (flush_cnt),
      .wait_cnt         (wait_cnt)
   );

   // clock block
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      id_rs1           = 5'd0;
      id_rs2           = 5'd0;
      ex_rd            = 5'd0;
      ex_memread       = 1'b0;
      mem_branch_taken = 1'b0;
      mem_req          = 1'b0;
      mem_ready        = 1'b0;
   endtask

   task automatic set_load_use(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
      ex_memread = 1'b1;
      ex_rd      = rd;
      id_rs1     = rs1;
      id_rs2     = rs2;
   endtask

   task automatic check_ctl(input string tag, input logic pcw, input logic bub,
                            input logic fl, input logic hold);
      check({tag, ".pc_write"}, pc_write, pcw);
      check({tag, ".if_id_write"}, if_id_write, pcw);
      check({tag, ".ctrl_bubble"}, ctrl_bubble, bub);
      check({tag, ".if_id_flush"}, if_id_flush, fl);
      check({tag, ".id_ex_flush"}, id_ex_flush, fl);
      check({tag, ".ex_mem_flush"}, ex_mem_flush, fl);
      check({tag, ".pipe_hold"}, pipe_hold, hold);
   endtask

   initial begin
      reset = 1'b0;
      set_idle();
      #1;
      check_ctl("rst_comb", 1'b0, 1'b1, 1'b0, 1'b0);
      mem_req = 1'b1;
      #1;
      check("rst_freeze_hold", pipe_hold, 1'b0);
      mem_req = 1'b0;
      tick();
      tick();
      check("rst_state", hz_state, 0);
      check("rst_timeout", mem_timeout, 0);
      check("rst_stall_cnt", stall_cnt, 0);
      check("rst_flush_cnt", flush_cnt, 0);
      check("rst_wait_cnt", wait_cnt, 0);

      reset = 1'b1;
      #1;
      check_ctl("run", 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      check("run_state", hz_state, 0);

      // load-use on rs2
      set_load_use(5'd5, 5'd3, 5'd5);
      #1;
      check_ctl("lu_rs2", 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      check("lu_state", hz_state, 1);
      check("lu_stall_cnt", stall_cnt, PERF * 1);
      set_load_use(5'd7, 5'd7, 5'd2);
      #1;
      check("lu_rs1_pc_write", pc_write, 1'b0);
      ex_memread = 1'b0;
      #1;
      check("noload_pc_write", pc_write, 1'b1);
      set_load_use(5'd0, 5'd0, 5'd0);
      #1;
      check_ctl("x0", 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      check("x0_state", hz_state, 0);

      // branch flush beats a coincident load-use
      set_load_use(5'd9, 5'd9, 5'd1);
      mem_branch_taken = 1'b1;
      #1;
      check_ctl("flush_lu", 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      check("flush_state", hz_state, 2);
      check("flush_flush_cnt", flush_cnt, PERF * 1);
      check("flush_stall_cnt", stall_cnt, PERF * 1);
      set_idle();

      // three-cycle memory wait; branch during the wait is ignored
      mem_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         mem_branch_taken = (i == 1);
         #1;
         check_ctl($sformatf("wait%0d", i), 1'b0, 1'b0, 1'b0, 1'b1);
         tick();
         check($sformatf("wait%0d_state", i), hz_state, 3);
      end
      check("wait_wait_cnt", wait_cnt, PERF * 3);
      check("wait_timeout", mem_timeout, 0);
      mem_branch_taken = 1'b0;
      mem_ready        = 1'b1;
      #1;
      check_ctl("release", 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      check("release_state", hz_state, 0);

      // branch held during a freeze acts in the release cycle
      mem_ready        = 1'b0;
      mem_branch_taken = 1'b1;
      #1;
      check("frz_br_flush", if_id_flush, 1'b0);
      tick();
      check("frz_br_state", hz_state, 3);
      mem_ready = 1'b1;
      #1;
      check_ctl("rel_br", 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      check("rel_br_state", hz_state, 2);
      check("rel_br_timeout", mem_timeout, 0);
      check("rel_br_flush_cnt", flush_cnt, PERF * 2);
      set_idle();
      tick();

      // timeout after the fourth wait cycle, sticky while the freeze continues
      mem_req = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         tick();
         check($sformatf("to_cyc%0d", i), mem_timeout, (i >= 4) ? 1 : 0);
      end
      check("to_state", hz_state, 3);
      check("to_wait_cnt", wait_cnt, PERF * 10);
      reset = 1'b0;
      #1;
      check_ctl("to_rst", 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      check("to_rst_state", hz_state, 0);
      check("to_rst_timeout", mem_timeout, 0);
      check("to_rst_wait_cnt", wait_cnt, 0);
      check("to_rst_flush_cnt", flush_cnt, 0);
      reset = 1'b1;
      set_idle();
      tick();
      mem_req = 1'b1;
      tick();
      tick();
      tick();
      check("to_cleared", mem_timeout, 0);
      set_idle();
      tick();

      // reset aborts a stall
      set_load_use(5'd4, 5'd4, 5'd4);
      tick();
      check("abort_state", hz_state, 1);
      reset = 1'b0;
      tick();
      check("abort_rst_state", hz_state, 0);
      check("abort_stall_cnt", stall_cnt, 0);
      reset = 1'b1;

      // counter saturation over 2^CNT_W+2 stall cycles
      for (int i = 0; i < (1 << CNT_W) + 2; i++) tick();
      check("sat_state", hz_state, 1);
      check("sat_stall_cnt", stall_cnt, PERF * ((1 << CNT_W) - 1));
      set_idle();
      tick();
      check("final_state", hz_state, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
